if_fetch_ctrl: RTL and testbench

Instruction-fetch controller feeding the IF/ID pipeline register. Owns the program counter and issues requests to the instruction memory over a valid/ready handshake. Delivers one fetched instruction plus its link PC (PC+4) to the IF/ID register. Honours hazard freeze and branch redirect, and tolerates multi-cycle memory latency by presenting NOP bubbles while no instruction is available.

---
 rtl/if_pkg.sv | 6 +
 rtl/if_fetch_ctrl.sv | 64 ++++++
 tb/tb_if_fetch_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch controller.
package if_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: owns the PC, fetches over valid/ready and feeds the IF/ID register.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Address,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        valid,
  output logic [31:0] PC_Out,
  output logic [31:0] Instruction_Out,
  output logic [31:0] fetch_count
);
  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        xfer;
  logic        handoff;
  assign mem_req  = !Branch_Taken && (state == FETCH || (state == HOLD && !freeze));
  assign mem_addr = pc;
  assign pc_next  = pc + PC_STEP;
  assign xfer     = mem_req && mem_ready;
  assign handoff  = valid && !freeze && !Branch_Taken;
  // A transfer can only happen in FETCH or unfrozen HOLD, so it also covers back-to-back captures.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      valid           <= 1'b0;
      PC_Out          <= 32'h0;
      Instruction_Out <= NOP;
      fetch_count     <= 32'h0;
    end else begin
      if (handoff) fetch_count <= fetch_count + 32'd1;
      if (Branch_Taken) begin
        pc              <= Branch_Address;
        valid           <= 1'b0;
        PC_Out          <= 32'h0;
        Instruction_Out <= NOP;
        state           <= FETCH;
      end else if (xfer) begin
        PC_Out          <= pc_next;
        Instruction_Out <= mem_rdata;
        valid           <= 1'b1;
        pc              <= pc_next;
        state           <= HOLD;
      end else if (state == IDLE) begin
        state <= FETCH;
      end else if (state == HOLD && !freeze) begin
        valid           <= 1'b0;
        Instruction_Out <= NOP;
        state           <= FETCH;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scoreboard bench for the instruction-fetch controller.
module tb_if_fetch_ctrl;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        freeze = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Address = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata;
  logic        valid;
  logic [31:0] PC_Out;
  logic [31:0] Instruction_Out;
  logic [31:0] fetch_count;
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] pc_out2;
  logic [31:0] instr2;
  logic [31:0] count2;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];

  always #5 CLK = ~CLK;
  assign mem_rdata = mem_addr ^ KEY;

  if_fetch_ctrl dut (
    .CLK(CLK), .RST(RST), .freeze(freeze), .Branch_Taken(Branch_Taken),
    .Branch_Address(Branch_Address), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .valid(valid), .PC_Out(PC_Out),
    .Instruction_Out(Instruction_Out), .fetch_count(fetch_count)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(CLK), .RST(RST), .freeze(1'b0), .Branch_Taken(1'b0),
    .Branch_Address(32'h0), .mem_req(req2), .mem_addr(addr2),
    .mem_ready(1'b1), .mem_rdata(addr2 ^ KEY), .valid(valid2), .PC_Out(pc_out2),
    .Instruction_Out(instr2), .fetch_count(count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) q.push_back(first + 32'(4 * i));
  endtask

  // Monitor: every handoff consumes one expected PC_Out; the instruction follows from the memory pattern.
  always @(negedge CLK) begin
    if (RST) begin
      if (!valid) chk("nop_when_invalid", Instruction_Out, 32'h0);
      if (valid && !freeze && !Branch_Taken) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_handoff: got PC_Out %h expected no handoff", PC_Out);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          chk("handoff_pc", PC_Out, e);
          chk("handoff_instr", Instruction_Out, (e - 32'd4) ^ KEY);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_pc_out", PC_Out, 32'h0);
    chk("rst_instr", Instruction_Out, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    push_seq(32'd4, 10);
    step(1);
    #1;
    chk("first_req", 32'(mem_req), 32'h1);
    chk("first_addr", mem_addr, 32'h0);
    chk("not_yet_valid", 32'(valid), 32'h0);
    step(1);
    chk("valid_after_edge2", 32'(valid), 32'h1);
    chk("wrap_pc0", pc_out2, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_pc1", pc_out2, 32'h0000_0000);
    step(1);
    chk("wrap_pc2", pc_out2, 32'h0000_0004);
    step(8);
    freeze = 1'b1;
    #1;
    chk("count_after_10", fetch_count, 32'd10);
    for (int i = 0; i < 5; i++) begin
      chk("frz_req", 32'(mem_req), 32'h0);
      chk("frz_pc_out", PC_Out, 32'd44);
      chk("frz_instr", Instruction_Out, 32'd40 ^ KEY);
      chk("frz_count", fetch_count, 32'd10);
      step(1);
    end
    freeze = 1'b0;
    push_seq(32'd44, 2);
    step(1);
    mem_ready = 1'b0;
    push_seq(32'd52, 2);
    step(1);
    for (int i = 0; i < 9; i++) begin
      mem_ready = (i % 3 == 2);
      step(1);
    end
    // PC_Out 60 is now held; freeze then redirect so it is flushed without a handoff.
    freeze = 1'b1;
    mem_ready = 1'b1;
    step(1);
    Branch_Taken = 1'b1;
    Branch_Address = 32'h100;
    #1;
    chk("br_req_blocked", 32'(mem_req), 32'h0);
    step(1);
    Branch_Taken = 1'b0;
    freeze = 1'b0;
    push_seq(32'h104, 2);
    #1;
    chk("br_req", 32'(mem_req), 32'h1);
    chk("br_addr", mem_addr, 32'h100);
    chk("br_flush_valid", 32'(valid), 32'h0);
    chk("br_flush_pc", PC_Out, 32'h0);
    step(2);
    mem_ready = 1'b0;
    step(1);
    chk("count_after_br", fetch_count, 32'd16);
    chk("wait_req", 32'(mem_req), 32'h1);
    chk("wait_addr", mem_addr, 32'h108);
    chk("wait_valid", 32'(valid), 32'h0);
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_pc_out", PC_Out, 32'h0);
    chk("arst_count", fetch_count, 32'h0);
    chk("arst_req", 32'(mem_req), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    mem_ready = 1'b1;
    push_seq(32'd4, 2);
    step(1);
    #1;
    chk("restart_req", 32'(mem_req), 32'h1);
    chk("restart_addr", mem_addr, 32'h0);
    step(3);
    freeze = 1'b1;
    step(2);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
